// File: rtl/dna_mem_bank_if.sv
// ---------------------------------------------------------------------------
// dna_mem_bank_if
// Bus bundle for dna_mem_bank. Every per-channel field is a flat vector and
// channel c occupies slice [c*W +: W].
//   we          per-channel write enable
//   addw / din  per-channel write byte address / write data
//   addr / dout per-channel read byte address / registered read data
//   clear_start one-cycle clear request; clear_mask is sampled with it
//   clear_busy  clear engine active; clear_done one-cycle completion pulse
// master = controller / PE array side, slave = the memory bank.
// ---------------------------------------------------------------------------
interface dna_mem_bank_if #(
    parameter int NUM_CH     = 18,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_CH-1:0]            we;
    logic [NUM_CH*ADDR_WIDTH-1:0] addw;
    logic [NUM_CH*DATA_WIDTH-1:0] din;
    logic [NUM_CH*ADDR_WIDTH-1:0] addr;
    logic [NUM_CH*DATA_WIDTH-1:0] dout;
    logic                         clear_start;
    logic [NUM_CH-1:0]            clear_mask;
    logic                         clear_busy;
    logic                         clear_done;

    modport master (
        output we, addw, din, addr, clear_start, clear_mask,
        input  dout, clear_busy, clear_done
    );

    modport slave (
        input  we, addw, din, addr, clear_start, clear_mask,
        output dout, clear_busy, clear_done
    );
endinterface

// File: rtl/dna_mem_bank.sv
// ---------------------------------------------------------------------------
// dna_mem_bank
// Multi-channel word memory for the DNA alignment datapath: channel 0 holds
// the read sequence, channel 1 the reference, channels 2.. the score
// matrices. Each channel has its own write port and a registered,
// write-first read port. A clear engine zeroes the masked channels one word
// per cycle between alignment jobs.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (array contents are not reset)
//   bus  dna_mem_bank_if.slave (write/read ports and clear control)
// ---------------------------------------------------------------------------

// One channel: storage array, write arbitration against the clear engine,
// and the registered read path.
module dna_mem_bank_ch #(
    parameter int DEPTH      = 128,
    parameter int IDX_W      = 7,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addw_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  clr_i,      // clear engine owns this channel this cycle
    input  logic [IDX_W-1:0]      clr_idx_i,  // word being zeroed
    output logic [DATA_WIDTH-1:0] dout_o
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IDX_W-1:0]      widx, ridx;
    logic                  w_ok, r_ok, user_we;
    logic [DATA_WIDTH-1:0] rd_d, rd_q;
    logic                  unused_lsbs;

    // Byte address -> word index; any bit above the index makes it out of range.
    assign widx = addw_i[IDX_W+1:2];
    assign ridx = addr_i[IDX_W+1:2];
    assign w_ok = ((addw_i >> (IDX_W + 2)) == '0);
    assign r_ok = ((addr_i >> (IDX_W + 2)) == '0);
    assign unused_lsbs = ^{addw_i[1:0], addr_i[1:0]};

    // Clear write wins; a user write to a channel under clear is dropped.
    assign user_we = we_i && w_ok && !clr_i;

    always_ff @(posedge clk) begin
        if (clr_i)
            mem[clr_idx_i] <= '0;
        else if (user_we)
            mem[widx] <= din_i;
    end

    // Write-first: same-cycle bypass of an accepted user write, or of the
    // zero being written by the clear engine.
    always_comb begin
        rd_d = '0;
        if (r_ok) begin
            if (user_we && (widx == ridx))
                rd_d = din_i;
            else if (clr_i && (clr_idx_i == ridx))
                rd_d = '0;
            else
                rd_d = mem[ridx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_q <= '0;
        else
            rd_q <= rd_d;
    end

    assign dout_o = rd_q;
endmodule

module dna_mem_bank #(
    parameter int MEM_BYTES  = 512,
    parameter int NUM_MATRIX = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    dna_mem_bank_if.slave  bus
);
    localparam int DEPTH  = MEM_BYTES / 4;
    localparam int NUM_CH = NUM_MATRIX + 2;
    localparam int IDX_W  = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic              clearing;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
        end
    end

    // clear_start is only looked at in IDLE, so requests during CLEAR and
    // the DONE cycle are ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        case (state_q)
            S_IDLE: begin
                if (bus.clear_start) begin
                    state_d = S_CLEAR;
                    mask_d  = bus.clear_mask;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == LAST)
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status is decoded straight from the state register so an async reset
    // drops both flags immediately.
    assign clearing       = (state_q == S_CLEAR);
    assign bus.clear_busy = clearing;
    assign bus.clear_done = (state_q == S_DONE);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        dna_mem_bank_ch #(
            .DEPTH      (DEPTH),
            .IDX_W      (IDX_W),
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .we_i      (bus.we[c]),
            .addw_i    (bus.addw[c*ADDR_WIDTH +: ADDR_WIDTH]),
            .din_i     (bus.din[c*DATA_WIDTH +: DATA_WIDTH]),
            .addr_i    (bus.addr[c*ADDR_WIDTH +: ADDR_WIDTH]),
            .clr_i     (clearing && mask_q[c]),
            .clr_idx_i (cnt_q),
            .dout_o    (bus.dout[c*DATA_WIDTH +: DATA_WIDTH])
        );
    end
endmodule

// File: tb/tb_dna_mem_bank.sv
module tb_dna_mem_bank;
    localparam int NCH  = 18;
    localparam int DEP  = 128;
    localparam int SCH  = 6;
    localparam int SDEP = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dna_mem_bank_if #(.NUM_CH(NCH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    dna_mem_bank_if #(.NUM_CH(SCH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) sbus ();

    dna_mem_bank #(.MEM_BYTES(512), .NUM_MATRIX(16), .ADDR_WIDTH(32), .DATA_WIDTH(32))
        dut (.clk(clk), .rst(rst), .bus(bus));
    dna_mem_bank #(.MEM_BYTES(64), .NUM_MATRIX(4), .ADDR_WIDTH(32), .DATA_WIDTH(32))
        dut_s (.clk(clk), .rst(rst), .bus(sbus));

    int ntests = 0;
    int nfail  = 0;
    logic [31:0] model  [NCH][DEP];
    logic [31:0] smodel [SCH][SDEP];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [7:0] salt, input int c, input int i);
        logic [31:0] r;
        r = {salt, 8'(c), 16'(i)};
        return r;
    endfunction

    task automatic fill(input logic [7:0] salt);
        for (int i = 0; i < DEP; i++) begin
            bus.we = '1;
            for (int c = 0; c < NCH; c++) begin
                bus.addw[c*32 +: 32] = 32'(i * 4);
                bus.din[c*32 +: 32]  = pat(salt, c, i);
                model[c][i]          = pat(salt, c, i);
            end
            tick();
        end
        bus.we = '0;
    endtask

    task automatic verify_all(input string tag);
        for (int i = 0; i < DEP; i++) begin
            for (int c = 0; c < NCH; c++) bus.addr[c*32 +: 32] = 32'(i * 4);
            tick();
            for (int c = 0; c < NCH; c++)
                chk($sformatf("%s c%0d i%0d", tag, c, i), bus.dout[c*32 +: 32], model[c][i]);
        end
    endtask

    task automatic sfill(input logic [7:0] salt);
        for (int i = 0; i < SDEP; i++) begin
            sbus.we = '1;
            for (int c = 0; c < SCH; c++) begin
                sbus.addw[c*32 +: 32] = 32'(i * 4);
                sbus.din[c*32 +: 32]  = pat(salt, c, i);
                smodel[c][i]          = pat(salt, c, i);
            end
            tick();
        end
        sbus.we = '0;
    endtask

    task automatic sverify(input string tag);
        for (int i = 0; i < SDEP; i++) begin
            for (int c = 0; c < SCH; c++) sbus.addr[c*32 +: 32] = 32'(i * 4);
            tick();
            for (int c = 0; c < SCH; c++)
                chk($sformatf("%s c%0d i%0d", tag, c, i), sbus.dout[c*32 +: 32], smodel[c][i]);
        end
    endtask

    initial begin
        int busy_n, done_n, done_at, overlap;

        rst = 1'b1;
        bus.we = '0;  bus.addw = '0;  bus.din = '0;  bus.addr = '0;
        bus.clear_start = 1'b0;  bus.clear_mask = '0;
        sbus.we = '0; sbus.addw = '0; sbus.din = '0; sbus.addr = '0;
        sbus.clear_start = 1'b0; sbus.clear_mask = '0;
        tick(); tick();

        // reset state
        chk("rst busy", 32'(bus.clear_busy), 32'd0);
        chk("rst done", 32'(bus.clear_done), 32'd0);
        chk("rst dout0", bus.dout[0 +: 32], 32'd0);
        chk("rst dout17", bus.dout[17*32 +: 32], 32'd0);
        chk("rst sbusy", 32'(sbus.clear_busy), 32'd0);
        rst = 1'b0;
        tick();

        // basic write / read, with address LSB aliasing
        bus.we[0] = 1'b1;  bus.addw[0 +: 32] = 32'h10;  bus.din[0 +: 32] = 32'hDEAD_BEEF;
        bus.we[17] = 1'b1; bus.addw[17*32 +: 32] = 32'h1FC; bus.din[17*32 +: 32] = 32'h1234_5678;
        tick();
        bus.we = '0;
        bus.addr[0 +: 32] = 32'h10; bus.addr[17*32 +: 32] = 32'h1FC;
        tick();
        chk("rd ch0", bus.dout[0 +: 32], 32'hDEAD_BEEF);
        chk("rd ch17", bus.dout[17*32 +: 32], 32'h1234_5678);
        bus.addr[0 +: 32] = 32'h13;
        tick();
        chk("alias 0x13", bus.dout[0 +: 32], 32'hDEAD_BEEF);

        // write-first on channel 5, index 7
        bus.we[5] = 1'b1; bus.addw[5*32 +: 32] = 32'h1C; bus.din[5*32 +: 32] = 32'h0BAD_0BAD;
        tick();
        bus.din[5*32 +: 32] = 32'hA5A5_A5A5; bus.addr[5*32 +: 32] = 32'h1C;
        tick();
        chk("wfirst", bus.dout[5*32 +: 32], 32'hA5A5_A5A5);
        bus.we = '0;
        tick();
        chk("wfirst stored", bus.dout[5*32 +: 32], 32'hA5A5_A5A5);

        // out-of-range write dropped, out-of-range read returns 0
        bus.we[0] = 1'b1; bus.addw[0 +: 32] = 32'h0; bus.din[0 +: 32] = 32'h1111_1111;
        tick();
        bus.addw[0 +: 32] = 32'h200; bus.din[0 +: 32] = 32'h2222_2222;
        tick();
        bus.we = '0; bus.addr[0 +: 32] = 32'h0;
        tick();
        chk("oor wr dropped", bus.dout[0 +: 32], 32'h1111_1111);
        bus.addr[0 +: 32] = 32'h200;
        tick();
        chk("oor rd", bus.dout[0 +: 32], 32'd0);

        // masked clear with contention and ignored restarts
        fill(8'hA1);
        bus.clear_mask = 18'h3FFFC; bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0; bus.clear_mask = '0;
        busy_n = 0; done_n = 0; done_at = 0; overlap = 0;
        for (int n = 1; n <= 140; n++) begin
            if (bus.clear_busy) busy_n++;
            if (bus.clear_done) begin
                done_n++; done_at = n;
                if (bus.clear_busy) overlap++;
            end
            bus.clear_start = (n == 60) || (n == DEP + 1);
            bus.clear_mask  = (n == 60) ? 18'h1 : ((n == DEP + 1) ? '1 : '0);
            if (n == 110) begin
                bus.we[3] = 1'b1; bus.addw[3*32 +: 32] = 32'd400; bus.din[3*32 +: 32] = 32'hFFFF_FFFF;
                bus.we[0] = 1'b1; bus.addw[0 +: 32]    = 32'd400; bus.din[0 +: 32]    = 32'hFFFF_FFFF;
                model[0][100] = 32'hFFFF_FFFF;
            end else begin
                bus.we = '0;
            end
            tick();
        end
        chk("clr busy len", 32'(busy_n), 32'd128);
        chk("clr done cnt", 32'(done_n), 32'd1);
        chk("clr done at", 32'(done_at), 32'd129);
        chk("clr overlap", 32'(overlap), 32'd0);
        for (int c = 2; c < NCH; c++)
            for (int i = 0; i < DEP; i++) model[c][i] = 32'd0;
        verify_all("clr");

        // reset 40 cycles into a full clear
        fill(8'hB2);
        for (int c = 0; c < NCH; c++) bus.addr[c*32 +: 32] = 32'(127 * 4);
        tick();
        bus.clear_mask = '1; bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0; bus.clear_mask = '0;
        repeat (40) tick();
        chk("pre-rst busy", 32'(bus.clear_busy), 32'd1);
        chk("pre-rst dout", bus.dout[9*32 +: 32], pat(8'hB2, 9, 127));
        rst = 1'b1;
        #1;
        chk("rst busy drop", 32'(bus.clear_busy), 32'd0);
        chk("rst done low", 32'(bus.clear_done), 32'd0);
        chk("rst dout0", bus.dout[0 +: 32], 32'd0);
        chk("rst dout9", bus.dout[9*32 +: 32], 32'd0);
        chk("rst dout17", bus.dout[17*32 +: 32], 32'd0);
        tick();
        rst = 1'b0;
        done_n = 0;
        for (int n = 0; n < DEP + 10; n++) begin
            if (bus.clear_done || bus.clear_busy) done_n++;
            tick();
        end
        chk("no done after abort", 32'(done_n), 32'd0);
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < 40; i++) model[c][i] = 32'd0;
        verify_all("abort");

        // small configuration: 6 channels, depth 16
        sfill(8'hC3);
        sbus.clear_mask = 6'b111100; sbus.clear_start = 1'b1;
        tick();
        sbus.clear_start = 1'b0; sbus.clear_mask = '0;
        busy_n = 0; done_n = 0; done_at = 0;
        for (int n = 1; n <= 30; n++) begin
            if (sbus.clear_busy) busy_n++;
            if (sbus.clear_done) begin done_n++; done_at = n; end
            tick();
        end
        chk("s busy len", 32'(busy_n), 32'd16);
        chk("s done cnt", 32'(done_n), 32'd1);
        chk("s done at", 32'(done_at), 32'd17);
        for (int c = 2; c < SCH; c++)
            for (int i = 0; i < SDEP; i++) smodel[c][i] = 32'd0;
        sverify("sclr");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/dna_mem_bank.md
# dna_mem_bank

Parametrised multi-channel word memory for the DNA alignment datapath. It holds one read-sequence channel, one reference-sequence channel and NUM_MATRIX score-matrix channels, each with an independent write port and read port. It adds two things over per-channel single-port instances: a registered, write-first read path, and a hardware clear engine that zeroes the selected channels between alignment jobs. It sits between the alignment controller/PE array and storage.

## Interface

Parameters:
- MEM_BYTES, 512, bytes per channel; DEPTH = MEM_BYTES/4 words (128 by default); DEPTH is a power of two
- NUM_MATRIX, 16, number of score-matrix channels
- ADDR_WIDTH, 32, byte-address width
- DATA_WIDTH, 32, word width
- NUM_CH, derived, NUM_MATRIX+2; channel 0 = read sequence, 1 = reference, 2..NUM_CH-1 = matrix 0..NUM_MATRIX-1
- IDX_W, derived, clog2(DEPTH)

Ports:
- clk  in  1  clock; everything is rising-edge
- rst  in  1  asynchronous, active-high reset
- we  in  NUM_CH  per-channel write enable
- addw  in  NUM_CH*ADDR_WIDTH  per-channel write byte address; channel c uses slice [c*ADDR_WIDTH +: ADDR_WIDTH]
- din  in  NUM_CH*DATA_WIDTH  per-channel write data
- addr  in  NUM_CH*ADDR_WIDTH  per-channel read byte address
- dout  out  NUM_CH*DATA_WIDTH  per-channel registered read data
- clear_start  in  1  one-cycle request to start the clear engine
- clear_mask  in  NUM_CH  channels to clear; sampled with clear_start
- clear_busy  out  1  clear engine active
- clear_done  out  1  one-cycle pulse when a clear completes

## Operation

- Addresses are word-aligned:
  - word index = byte address bits [IDX_W+1:2]; bits [1:0] are ignored.
  - Any higher bit set makes the address out of range.
  - An out-of-range write is dropped.
  - An out-of-range read returns 0.
- Write: if we[c] is high at a clock edge, mem[c][idx] is updated with din slice c.
- Read: dout slice c is registered from mem[c][idx(addr c)].
- Write-first: if the read and write of the same channel hit the same in-range index in the same cycle, dout returns that cycle's din.
- Clear FSM has three states: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR when clear_start is high. At that edge clear_mask is latched into mask_q and the word counter is set to 0.
  - CLEAR: each cycle, word cnt of every channel in mask_q is written with 0, then cnt increments. When cnt = DEPTH-1 the state moves to DONE.
  - DONE: clear_done is high for one cycle, then the state returns to IDLE.
- clear_start is ignored outside IDLE.
- During CLEAR, user writes to channels in mask_q are dropped; the clear write has priority. Channels not in mask_q keep normal write/read behaviour.
- A read of a masked channel during CLEAR returns the current array contents (which may be partially cleared). Write-first bypass applies only to accepted user writes. A read of the word being cleared in that cycle returns 0.
- Array contents are not affected by rst. Simulation initial contents are undefined.

## Timing

- Reset values: dout = 0 for all channels; clear_busy = 0; clear_done = 0; FSM = IDLE; cnt = 0; mask_q = 0.
- Read latency is 1 cycle. An address presented in cycle t gives data on dout in cycle t+1.
- Write latency: the word is stored at the edge ending cycle t. A read issued in cycle t+1 returns it.
- Clear timing, with clear_start high in cycle k:
  - clear_busy is high in cycles k+1 .. k+DEPTH.
  - Word i is zeroed at the edge ending cycle k+1+i.
  - clear_done is high in cycle k+DEPTH+1, with clear_busy low in that cycle.
  - A new clear_start is accepted at the earliest in cycle k+DEPTH+2.
- clear_start is accepted only from IDLE, so it is ignored in cycles k+1 .. k+DEPTH+1. That covers both CLEAR and the DONE cycle.
- rst asserted mid-clear:
  - FSM goes to IDLE and clear_busy and clear_done drop immediately.
  - Words already zeroed stay zero; the rest are unchanged.
  - No clear_done is produced for the aborted clear.
- An all-zero clear_mask still runs the full DEPTH-cycle sequence and pulses clear_done.

## Test plan

- Write/read basic:
  - Write 0xDEAD_BEEF to channel 0 at byte 0x10 and 0x1234_5678 to channel 17 at byte 0x1FC.
  - Read both next cycle -> the data appears one cycle after addr.
  - Byte 0x13 aliases 0x10 -> returns 0xDEAD_BEEF.
- Write-first and out of range:
  - Channel 5 reads and writes index 7 in the same cycle with din 0xA5A5_A5A5 -> dout = 0xA5A5_A5A5 next cycle.
  - Write to byte 0x200 is dropped.
  - Read of byte 0x200 -> 0.
- Clear, masked:
  - Fill all channels with nonzero data.
  - Pulse clear_start with clear_mask = 0x3FFFC -> clear_busy high for exactly 128 cycles, then clear_done high for 1 cycle.
  - Channels 2..17 read 0 at every index; channels 0 and 1 are unchanged.
- Clear contention:
  - During CLEAR, write 0xFFFF_FFFF to masked channel 3 at index 100 and to unmasked channel 0 at index 100.
  - After done -> channel 3 index 100 = 0; channel 0 index 100 = 0xFFFF_FFFF.
  - A second clear_start during busy has no effect: busy length stays 128 and there is only one done pulse.
- Reset mid-clear:
  - Assert rst 40 cycles into a full clear -> clear_busy = 0 and dout = 0 immediately.
  - Indices 0..39 read 0; indices 40..127 keep their prior data.
  - No clear_done is seen.
- Parameter sweep:
  - Run with NUM_MATRIX = 4 and MEM_BYTES = 64 (DEPTH = 16).
  - Repeat the clear scenario -> clear_busy lasts 16 cycles and all 6 channels behave correctly.
